// File: rtl/ped_countdown_timer.sv
// Pedestrian-crossing countdown controller: steady walk, displayed BCD countdown
// with a flashing walk lamp, clearance hold, then a one-cycle done pulse.
module ped_countdown_timer #(
  parameter int CNT_W     = 5,
  parameter int WALK_SEC  = 3,
  parameter int COUNT_SEC = 23,
  parameter int FLASH_SEC = 5,
  parameter int CLEAR_SEC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             light_out,
  output logic [CNT_W-1:0] ped_signal_time,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [1:0]       leading_zero,
  output logic             walk_lamp,
  output logic             stop_lamp,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WALK  = 2'd1,
    S_COUNT = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WALK_T  = CNT_W'(WALK_SEC);
  localparam logic [CNT_W-1:0] COUNT_T = CNT_W'(COUNT_SEC);
  localparam logic [CNT_W-1:0] CLEAR_T = CNT_W'(CLEAR_SEC);
  localparam logic [CNT_W-1:0] FLASH_T = CNT_W'(FLASH_SEC);
  localparam logic [CNT_W-1:0] ONE_T   = CNT_W'(1);
  localparam int               EXT_W   = (CNT_W > 7) ? CNT_W : 7;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             done_q, done_d;

  logic             walk_raw, stop_raw;
  logic [EXT_W-1:0] disp_ext;
  logic [7:0]       bcd_pair;

  // Display values never exceed 99, so a 7-bit constant divide is enough.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return {t[3:0], 4'(v - t * 7'd10)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    if (light_out) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_WALK;
            timer_d = WALK_T;
          end
        end
        S_WALK: begin
          if (tick) begin
            if (timer_q == ONE_T) begin
              state_d = S_COUNT;
              timer_d = COUNT_T;
            end else begin
              timer_d = timer_q - ONE_T;
            end
          end
        end
        S_COUNT: begin
          if (tick) begin
            if (timer_q == ONE_T) begin
              state_d = S_CLEAR;
              timer_d = CLEAR_T;
            end else begin
              timer_d = timer_q - ONE_T;
            end
          end
        end
        S_CLEAR: begin
          if (tick) begin
            if (timer_q == ONE_T) begin
              state_d = S_IDLE;
              timer_d = '0;
              done_d  = 1'b1;
            end else begin
              timer_d = timer_q - ONE_T;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Moore decode; light_out only gates the lamps combinationally.
  always_comb begin
    ped_signal_time = '0;
    walk_raw        = 1'b0;
    stop_raw        = 1'b0;
    unique case (state_q)
      S_IDLE:  stop_raw = 1'b1;
      S_WALK:  walk_raw = 1'b1;
      S_COUNT: begin
        ped_signal_time = timer_q;
        walk_raw        = (timer_q > FLASH_T) | timer_q[0];
      end
      S_CLEAR: stop_raw = 1'b1;
      default: stop_raw = 1'b1;
    endcase
  end

  assign disp_ext     = EXT_W'(ped_signal_time);
  assign bcd_pair     = bcd_split(disp_ext[6:0]);
  assign bcd_tens     = bcd_pair[7:4];
  assign bcd_ones     = bcd_pair[3:0];
  assign leading_zero = (state_q == S_COUNT) ? {(bcd_tens == 4'd0), 1'b0} : 2'b11;
  assign walk_lamp    = walk_raw & ~light_out;
  assign stop_lamp    = stop_raw & ~light_out;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: doc/ped_countdown_timer.md
# ped_countdown_timer

Parametrised pedestrian-crossing countdown controller for the traffic-light system. It holds its own phase timer and sequences a steady walk phase, a displayed countdown and a clearance hold. It drives the walk/stop lamps, the two-digit BCD countdown with per-digit blanking, and a completion pulse. It sits between the intersection sequencer (start, light_out) and the 7-segment display drivers, and runs from the system clock with a 1 s tick enable.

## Interface
- CNT_W, 5: timer and `ped_signal_time` width; must satisfy 2^CNT_W > max(WALK_SEC, COUNT_SEC, CLEAR_SEC)
- WALK_SEC, 3: ticks of steady walk before the countdown starts (>=1)
- COUNT_SEC, 23: first displayed countdown value (1..99)
- FLASH_SEC, 5: walk lamp flashes once the displayed value is <= FLASH_SEC (0 disables flashing)
- CLEAR_SEC, 3: ticks of stop-lamp hold after the countdown ends (>=1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle 1 s enable pulse
- start  in  1  pedestrian phase request pulse from sequencer
- light_out  in  1  lamp-out / blanking override
- ped_signal_time  out  CNT_W  displayed countdown value (binary); 0 when not displaying
- bcd_tens  out  4  tens digit of ped_signal_time
- bcd_ones  out  4  ones digit of ped_signal_time
- leading_zero  out  2  bit1 = blank tens, bit0 = blank ones (1 = blank)
- walk_lamp  out  1  walk indication
- stop_lamp  out  1  don't-walk indication
- busy  out  1  high in WALK, COUNT, CLEAR
- done  out  1  one-cycle pulse on CLEAR -> IDLE

## Operation
- Registers: 2-bit state, CNT_W-bit timer, done flop. All other outputs decode state and timer only (Moore), with no input-to-output paths.
- States and transitions, all evaluated at the clk edge, in priority order:
  - light_out=1 in any state: state -> IDLE, timer -> 0, done -> 0.
  - IDLE: start=1 -> WALK, timer = WALK_SEC. A tick in the same cycle is ignored.
  - WALK: tick with timer==1 -> COUNT, timer = COUNT_SEC. Any other tick decrements timer.
  - COUNT: tick with timer==1 -> CLEAR, timer = CLEAR_SEC. Any other tick decrements timer.
  - CLEAR: tick with timer==1 -> IDLE, timer = 0, done = 1 for one cycle. Any other tick decrements timer.
- start outside IDLE is ignored; there is no restart or extension.
- Output decode:
  - ped_signal_time = timer in COUNT, otherwise 0.
  - bcd_tens = ped_signal_time / 10 and bcd_ones = ped_signal_time % 10, as a combinational divide-by-10 on at most 7 bits.
  - leading_zero = 2'b11 outside COUNT or when light_out is registered as IDLE. In COUNT it is {bcd_tens==0, 1'b0}.
  - walk_lamp = 1 in WALK. In COUNT it is (timer > FLASH_SEC) | timer[0], so it is lit on odd values within the flash window. It is 0 otherwise.
  - stop_lamp = 1 in IDLE and CLEAR, 0 in WALK and COUNT.
  - While light_out=1, walk_lamp = stop_lamp = 0 (lamp-out). This is the only combinational term, an AND-gate on the lamps.
- Reset values: state IDLE, timer 0, ped_signal_time 0, bcd 0/0, leading_zero 2'b11, walk_lamp 0, stop_lamp 1 (light_out=0), busy 0, done 0.
- Reset mid-phase aborts immediately to IDLE with no done pulse.

## Timing
- start sampled at edge N: busy=1, walk_lamp=1, stop_lamp=0 from cycle N+1.
- WALK lasts exactly WALK_SEC ticks, COUNT exactly COUNT_SEC ticks, CLEAR exactly CLEAR_SEC ticks.
- Display changes one cycle after the tick edge; value sequence is COUNT_SEC, COUNT_SEC-1, ..., 1, then blank.
- done is high for the single cycle after the final CLEAR tick edge; busy=0 in that same cycle.
- light_out takes effect at the next edge for state and timer. Lamps blank in the same cycle.
- tick and start may be asserted in any cycle. A tick outside WALK/COUNT/CLEAR has no effect.

## Test plan
- Reset release, no stimulus -> stop_lamp=1, walk_lamp=0, leading_zero=2'b11, ped_signal_time=0, busy=0.
- Defaults; start, then 3 ticks -> walk_lamp=1 with display blank; after 3rd tick ped_signal_time=23, bcd 2/3, leading_zero=2'b00.
- Continue ticking -> value 9 gives leading_zero=2'b10 and bcd 0/9. Values 5,4,3,2,1 give walk_lamp 1,0,1,0,1. The tick at 1 gives blank and stop_lamp=1. 3 more ticks give done pulse of width 1 and busy=0.
- light_out=1 at display value 12 -> lamps 0 same cycle; next cycle state IDLE, leading_zero=2'b11, no done. Drop light_out -> stop_lamp=1.
- start with tick in the same cycle from IDLE -> timer loads 3 (not 2), WALK spans 3 further ticks. A second start during COUNT is ignored (sequence unchanged).
- Async rst asserted mid-CLEAR between edges -> outputs at reset values immediately, no done. Repeat with CNT_W=7, COUNT_SEC=99 -> first display bcd 9/9.
